stop_watch_ctrl: RTL and testbench

//  Front-panel controller sequencing the stop_watch counter datapath from two push buttons.
//  - Turns raw START/STOP and LAP/RESET button levels into single press events.
//  - Runs a 4-state FSM that drives the counter's cnt_en and clr.
//  - Captures lap times and selects live or lap time for the display.
//  - Sits between the board buttons and stop_watch; disp_time feeds the 7-seg driver.

---
 rtl/stop_watch_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 36 +++
 rtl/stop_watch_ctrl.sv | 155 +++++++++++++++
 tb/tb_stop_watch_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/stop_watch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stop_watch_pkg
// Brief    : Shared time format and controller state encoding for stop_watch.
// Revision : 1.0
// ============================================================================
package stop_watch_pkg;

  localparam int TIME_W = 19;

  typedef struct packed {
    logic [0:0] hr_1;
    logic [3:0] hr_0;
    logic [2:0] min_1;
    logic [3:0] min_0;
    logic [2:0] sec_1;
    logic [3:0] sec_0;
  } sw_time_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : Level debouncer; dout follows din after DEB_CYCLES stable cycles.
// Revision : 1.0
// ============================================================================
module btn_debounce #(
  parameter int DEB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Any cycle where din agrees with dout restarts the count, so glitches never accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stop_watch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stop_watch_ctrl
// Brief    : Button-driven run/pause/lap/clear sequencer for stop_watch.
//            Define STOP_WATCH_DEBOUNCE_EN to insert btn_debounce per button.
// Revision : 1.0
// ============================================================================
module stop_watch_ctrl
  import stop_watch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 20,
  parameter int LAP_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_ss,
  input  logic              btn_lr,
  input  logic [TIME_W-1:0] live_time,
  output logic              cnt_en,
  output logic              clr,
  output logic [1:0]        state_o,
  output logic              lap_active,
  output logic [LAP_W-1:0]  lap_cnt,
  output logic [TIME_W-1:0] disp_time
);

  if (SYNC_STAGES < 2 || DEB_CYCLES < 1) begin : g_param_check
    $error("stop_watch_ctrl: SYNC_STAGES must be >= 2 and DEB_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] lr_sync;
  logic                   ss_level;
  logic                   lr_level;
  logic                   ss_prev;
  logic                   lr_prev;
  logic                   ss_ev;
  logic                   lr_ev;
  sw_state_e              state;
  logic [TIME_W-1:0]      lap_time;

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync <= '0;
      lr_sync <= '0;
    end else begin
      ss_sync <= {ss_sync[SYNC_STAGES-2:0], btn_ss};
      lr_sync <= {lr_sync[SYNC_STAGES-2:0], btn_lr};
    end
  end

`ifdef STOP_WATCH_DEBOUNCE_EN
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
    .clk  (clk),
    .rst  (rst),
    .din  (ss_sync[SYNC_STAGES-1]),
    .dout (ss_level)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lr (
    .clk  (clk),
    .rst  (rst),
    .din  (lr_sync[SYNC_STAGES-1]),
    .dout (lr_level)
  );
`else
  assign ss_level = ss_sync[SYNC_STAGES-1];
  assign lr_level = lr_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_prev <= 1'b0;
      lr_prev <= 1'b0;
    end else begin
      ss_prev <= ss_level;
      lr_prev <= lr_level;
    end
  end

  assign ss_ev = ss_level & ~ss_prev;
  assign lr_ev = lr_level & ~lr_prev;

  // ss is tested first in every state, so a simultaneous lr event is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt_en     <= 1'b0;
      clr        <= 1'b0;
      lap_active <= 1'b0;
      lap_cnt    <= '0;
      lap_time   <= '0;
    end else begin
      clr <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_ev) begin
            state  <= RUN;
            cnt_en <= 1'b1;
          end else if (lr_ev) begin
            cnt_en   <= 1'b0;
            clr      <= 1'b1;
            lap_cnt  <= '0;
            lap_time <= '0;
          end
        end
        RUN: begin
          if (ss_ev) begin
            state  <= PAUSE;
            cnt_en <= 1'b0;
          end else if (lr_ev) begin
            state      <= LAP;
            lap_time   <= live_time;
            lap_active <= 1'b1;
            if (lap_cnt != '1) begin
              lap_cnt <= lap_cnt + 1'b1;
            end
          end
        end
        LAP: begin
          if (ss_ev) begin
            state      <= PAUSE;
            cnt_en     <= 1'b0;
            lap_active <= 1'b0;
          end else if (lr_ev) begin
            state      <= RUN;
            lap_active <= 1'b0;
          end
        end
        PAUSE: begin
          if (ss_ev) begin
            state  <= RUN;
            cnt_en <= 1'b1;
          end else if (lr_ev) begin
            state    <= IDLE;
            clr      <= 1'b1;
            lap_cnt  <= '0;
            lap_time <= '0;
          end
        end
        default: begin
          state      <= IDLE;
          cnt_en     <= 1'b0;
          lap_active <= 1'b0;
        end
      endcase
    end
  end

  assign state_o   = state;
  assign disp_time = lap_active ? lap_time : live_time;

endmodule
`default_nettype wire

// File: tb/tb_stop_watch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stop_watch_ctrl
// Brief    : Self-checking bench for stop_watch_ctrl (button events, FSM, laps).
// Revision : 1.0
// ============================================================================
module tb_stop_watch_ctrl;
  import stop_watch_pkg::*;

  localparam int S   = 2;
  localparam int DEB = 20;
`ifdef STOP_WATCH_DEBOUNCE_EN
  localparam int LAT = S + DEB + 1;
`else
  localparam int LAT = S + 1;
`endif

  typedef struct {
    sw_state_e         st;
    logic              cnt_en;
    logic              clr;
    logic              la;
    logic [3:0]        lc;
    logic [TIME_W-1:0] disp;
  } exp_t;

  typedef struct {
    logic              ss;
    logic              lr;
    logic [TIME_W-1:0] live;
    exp_t              e;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              btn_ss = 1'b0;
  logic              btn_lr = 1'b0;
  logic [TIME_W-1:0] live_time = '0;
  logic              cnt_en;
  logic              clr;
  logic [1:0]        state_o;
  logic              lap_active;
  logic [3:0]        lap_cnt;
  logic [TIME_W-1:0] disp_time;

  int        n_chk  = 0;
  int        n_fail = 0;
  exp_t      exp_q[$];
  sw_state_e cur_state = IDLE;

  stop_watch_ctrl #(.SYNC_STAGES(S), .DEB_CYCLES(DEB), .LAP_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_ss     (btn_ss),
    .btn_lr     (btn_lr),
    .live_time  (live_time),
    .cnt_en     (cnt_en),
    .clr        (clr),
    .state_o    (state_o),
    .lap_active (lap_active),
    .lap_cnt    (lap_cnt),
    .disp_time  (disp_time)
  );

  always #5 clk = ~clk;

  function automatic logic [TIME_W-1:0] tt(input int h, input int m, input int s);
    sw_time_t t;
    t.hr_1  = 1'(h / 10);
    t.hr_0  = 4'(h % 10);
    t.min_1 = 3'(m / 10);
    t.min_0 = 4'(m % 10);
    t.sec_1 = 3'(s / 10);
    t.sec_0 = 4'(s % 10);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag, input exp_t e);
    chk({tag, ".state"},  32'(state_o),    32'(e.st));
    chk({tag, ".cnt_en"}, 32'(cnt_en),     32'(e.cnt_en));
    chk({tag, ".clr"},    32'(clr),        32'(e.clr));
    chk({tag, ".lap_act"},32'(lap_active), 32'(e.la));
    chk({tag, ".lap_cnt"},32'(lap_cnt),    32'(e.lc));
    chk({tag, ".disp"},   32'(disp_time),  32'(e.disp));
  endtask

  // Drive a press, confirm nothing moves one cycle early, then score the outcome.
  task automatic press(input string tag, input logic ss, input logic lr,
                       input logic [TIME_W-1:0] live, input exp_t e);
    exp_t got;
    exp_q.push_back(e);
    @(negedge clk);
    live_time = live;
    btn_ss    = ss;
    btn_lr    = lr;
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk({tag, ".early"}, 32'(state_o), 32'(cur_state));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = exp_q.pop_front();
      compare(tag, got);
    end
    cur_state = e.st;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ".held_once"}, 32'(state_o), 32'(e.st));
    chk({tag, ".clr_1cyc"},  32'(clr),     32'd0);
    @(negedge clk);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    repeat (LAT + 2) @(posedge clk);
  endtask

  vec_t vecs[9];
  exp_t e;

  initial begin
    vecs[0] = '{1'b1, 1'b0, '0,            '{RUN,   1'b1, 1'b0, 1'b0, 4'd0, '0}};
    vecs[1] = '{1'b0, 1'b1, tt(0, 1, 23),  '{LAP,   1'b1, 1'b0, 1'b1, 4'd1, tt(0, 1, 23)}};
    vecs[2] = '{1'b0, 1'b1, tt(0, 1, 30),  '{RUN,   1'b1, 1'b0, 1'b0, 4'd1, tt(0, 1, 30)}};
    vecs[3] = '{1'b0, 1'b1, tt(0, 2, 0),   '{LAP,   1'b1, 1'b0, 1'b1, 4'd2, tt(0, 2, 0)}};
    vecs[4] = '{1'b1, 1'b0, tt(0, 2, 7),   '{PAUSE, 1'b0, 1'b0, 1'b0, 4'd2, tt(0, 2, 7)}};
    vecs[5] = '{1'b1, 1'b0, tt(0, 2, 7),   '{RUN,   1'b1, 1'b0, 1'b0, 4'd2, tt(0, 2, 7)}};
    vecs[6] = '{1'b1, 1'b1, tt(0, 2, 9),   '{PAUSE, 1'b0, 1'b0, 1'b0, 4'd2, tt(0, 2, 9)}};
    vecs[7] = '{1'b0, 1'b1, tt(0, 2, 9),   '{IDLE,  1'b0, 1'b1, 1'b0, 4'd0, tt(0, 2, 9)}};
    vecs[8] = '{1'b1, 1'b1, '0,            '{RUN,   1'b1, 1'b0, 1'b0, 4'd0, '0}};

    repeat (4) @(posedge clk);
    #1;
    compare("reset", '{IDLE, 1'b0, 1'b0, 1'b0, 4'd0, '0});
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

`ifdef STOP_WATCH_DEBOUNCE_EN
    @(negedge clk);
    btn_ss = 1'b1;
    repeat (5) @(negedge clk);
    btn_ss = 1'b0;
    repeat (2 * LAT) @(posedge clk);
    #1;
    chk("glitch.state",  32'(state_o), 32'(IDLE));
    chk("glitch.cnt_en", 32'(cnt_en),  32'd0);
`endif

    for (int i = 0; i < 9; i++) begin
      press($sformatf("vec%0d", i), vecs[i].ss, vecs[i].lr, vecs[i].live, vecs[i].e);
      if (vecs[i].e.la) begin
        @(negedge clk);
        live_time = vecs[i].live + 19'd5;
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d.frozen", i), 32'(disp_time), 32'(vecs[i].e.disp));
        chk($sformatf("vec%0d.running", i), 32'(cnt_en), 32'd1);
      end
    end

    // 17 laps from RUN: count saturates at 15 while lap_time keeps updating.
    for (int i = 0; i < 17; i++) begin
      e = '{LAP, 1'b1, 1'b0, 1'b1, 4'((i + 1 > 15) ? 15 : i + 1), tt(0, 3, i)};
      press($sformatf("lap%0d", i), 1'b0, 1'b1, tt(0, 3, i), e);
      e = '{RUN, 1'b1, 1'b0, 1'b0, 4'((i + 1 > 15) ? 15 : i + 1), tt(0, 4, i)};
      press($sformatf("ret%0d", i), 1'b0, 1'b1, tt(0, 4, i), e);
    end

    // Reset mid-run with START/STOP held: a fresh event follows reset release.
    @(negedge clk);
    btn_ss = 1'b1;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.state",   32'(state_o),    32'(IDLE));
    chk("rst.cnt_en",  32'(cnt_en),     32'd0);
    chk("rst.lap_cnt", 32'(lap_cnt),    32'd0);
    chk("rst.lap_act", 32'(lap_active), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk("rst_held.early", 32'(state_o), 32'(IDLE));
    @(posedge clk);
    #1;
    chk("rst_held.state",  32'(state_o), 32'(RUN));
    chk("rst_held.cnt_en", 32'(cnt_en),  32'd1);
    @(negedge clk);
    btn_ss = 1'b0;
    repeat (4) @(posedge clk);

    if (exp_q.size() != 0) begin
      chk("sb.leftover", 32'(exp_q.size()), 32'd0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
